gf180mcu_fd_sc_mcu9t5v0__cg_ctrl: RTL and testbench
===================================================

GF180MCU_FD_SC_MCU9T5V0__CG_CTRL -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__cg_ctrl

Interface
REQ-001 Parameter IDLE_W, default 8: width of the idle-hold limit and counter.
REQ-002 Parameter WAKE_CYC, default 2, legal range 1..15: number of cycles between E rising and ACK rising.
REQ-003 Port CLK  input  1  single free-running clock; all state updates on its rising edge.
REQ-004 Port RST  input  1  reset, synchronous, active-high.
REQ-005 Port REQ  input  1  consumer activity request; level-sensitive, sampled every CLK edge.
REQ-006 Port TE  input  1  scan/test enable override.
REQ-007 Port IDLE_LIM  input  IDLE_W  idle-hold cycles before gating; sampled only on DRAIN entry.
REQ-008 Port E  output  1  enable to the downstream integrated clock gate's E pin.
REQ-009 Port ACK  output  1  gated clock guaranteed running; consumer may issue work.
REQ-010 Port STATE  output  2  FSM state encoding: OFF=00, WAKE=01, ON=10, DRAIN=11.
REQ-011 Port WAKE_CNT  output  16  count of OFF->WAKE transitions; saturates at 16'hFFFF.

Function
REQ-012 FSM states: OFF, WAKE, ON, DRAIN; E and ACK shall be driven from registered state, not directly from REQ, except for the TE override in REQ-021.
REQ-013 OFF: E=0, ACK=0; REQ=1 at an edge -> WAKE on that edge, wake counter loaded with WAKE_CYC-1, WAKE_CNT incremented unless saturated.
REQ-014 WAKE: E=1, ACK=0; wake counter decrements each cycle; at an edge with counter==0 -> ON; the total time in WAKE shall be exactly WAKE_CYC cycles.
REQ-015 WAKE shall not abort: REQ falling during WAKE shall still complete to ON; the ON state then moves to DRAIN per REQ-016.
REQ-016 ON: E=1, ACK=1; REQ=0 at an edge -> DRAIN with the idle counter loaded from IDLE_LIM.
REQ-017 DRAIN: E=1, ACK=1; REQ=1 -> ON, with the idle counter discarded.
REQ-018 DRAIN with REQ=0: if idle counter==0 -> OFF, otherwise decrement; DRAIN lasts exactly IDLE_LIM+1 cycles when REQ stays low.
REQ-019 IDLE_LIM=0: DRAIN shall last one cycle, then OFF.
REQ-020 Changes to IDLE_LIM while in DRAIN shall have no effect on the current drain.
REQ-021 TE=1 shall force E=1 and ACK=1 combinationally; the FSM and counters shall advance exactly as if TE were 0.
REQ-022 STATE shall reflect the registered FSM state every cycle.
REQ-023 Entering OFF clears no counters; WAKE_CNT is cleared only by reset.
REQ-024 Unused encodings are unreachable; if forced, the FSM shall recover to OFF on the next edge.

Reset
REQ-025 RST=1 at an edge: STATE=OFF, E=0, ACK=0, wake and idle counters=0, WAKE_CNT=0, regardless of the current state (including mid-WAKE or mid-DRAIN).
REQ-026 During RST=1, REQ shall be ignored; the first transition shall occur at the first edge with RST=0.
REQ-027 TE override shall remain active during reset (E=1, ACK=1 while TE=1).

Verification
REQ-028 Wake: WAKE_CYC=2, REQ rises at edge 0 -> E=1 from edge 0, STATE=WAKE for 2 cycles, ACK=1 from edge 2, WAKE_CNT=1.
REQ-029 Drain: IDLE_LIM=3, REQ falls in ON at edge n -> STATE=DRAIN for edges n..n+3, OFF at n+4, E=0 and ACK=0 from n+4.
REQ-030 Re-request: REQ returns high at the second DRAIN cycle -> STATE=ON next edge, E and ACK never drop, WAKE_CNT unchanged.
REQ-031 Edge cases: IDLE_LIM=0 gives 1-cycle DRAIN; REQ pulse of 1 cycle in OFF gives a full WAKE, then ON, then DRAIN, then OFF.
REQ-032 Reset mid-WAKE and mid-DRAIN -> OFF, E=0, ACK=0, WAKE_CNT=0 on the next edge; TE=1 in OFF -> E=1, ACK=1, STATE=00.
REQ-033 Saturation: preload WAKE_CNT at 16'hFFFE and run 3 wake cycles -> WAKE_CNT holds at 16'hFFFF.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__cg_ctrl.sv
// Clock-gate controller: sequences the enable of a downstream integrated
// clock gate through OFF -> WAKE -> ON -> DRAIN -> OFF, so the consumer only
// sees ACK once the gated clock has had WAKE_CYC cycles to start, and the
// clock stays up for an idle-hold window after activity stops.
module gf180mcu_fd_sc_mcu9t5v0__cg_ctrl #(
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2   // 1..15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              TE,
  input  logic [IDLE_W-1:0] IDLE_LIM,
  output logic              E,
  output logic              ACK,
  output logic [1:0]        STATE,
  output logic [15:0]       WAKE_CNT
);

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_WAKE  = 2'b01,
    S_ON    = 2'b10,
    S_DRAIN = 2'b11
  } state_e;

  // Wake counter is loaded with WAKE_CYC-1 so WAKE lasts exactly WAKE_CYC cycles.
  localparam logic [3:0]  WAKE_LOAD = 4'(WAKE_CYC - 1);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  state_e            state_q, state_d;
  logic [3:0]        wake_q,  wake_d;
  logic [IDLE_W-1:0] idle_q,  idle_d;
  logic [15:0]       wcnt_q,  wcnt_d;

  // State and counter registers; synchronous reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_OFF;
      wake_q  <= '0;
      idle_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wake_q  <= wake_d;
      idle_q  <= idle_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d = state_q;
    wake_d  = wake_q;
    idle_d  = idle_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_OFF: begin
        if (REQ) begin
          state_d = S_WAKE;
          wake_d  = WAKE_LOAD;
          if (wcnt_q != CNT_MAX) wcnt_d = wcnt_q + 16'd1;
        end
      end
      S_WAKE: begin
        // WAKE never aborts: REQ is not looked at here.
        if (wake_q == '0) state_d = S_ON;
        else              wake_d  = wake_q - 4'd1;
      end
      S_ON: begin
        if (!REQ) begin
          state_d = S_DRAIN;
          idle_d  = IDLE_LIM;   // limit is captured once, on DRAIN entry
        end
      end
      S_DRAIN: begin
        if (REQ) begin
          state_d = S_ON;
          idle_d  = '0;
        end else if (idle_q == '0) begin
          state_d = S_OFF;
        end else begin
          idle_d  = idle_q - 1'b1;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // Outputs decode the registered state; TE forces the clock on regardless.
  always_comb begin
    E        = TE | (state_q != S_OFF);
    ACK      = TE | (state_q == S_ON) | (state_q == S_DRAIN);
    STATE    = state_q;
    WAKE_CNT = wcnt_q;
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__cg_ctrl.sv
// Directed bench for the clock-gate controller (IDLE_W=8, WAKE_CYC=2).
module tb_gf180mcu_fd_sc_mcu9t5v0__cg_ctrl;

  logic        CLK = 1'b0;
  logic        RST, REQ, TE;
  logic [7:0]  IDLE_LIM;
  logic        E, ACK;
  logic [1:0]  STATE;
  logic [15:0] WAKE_CNT;

  int n_chk = 0;
  int n_err = 0;

  gf180mcu_fd_sc_mcu9t5v0__cg_ctrl #(.IDLE_W(8), .WAKE_CYC(2)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .TE(TE), .IDLE_LIM(IDLE_LIM),
    .E(E), .ACK(ACK), .STATE(STATE), .WAKE_CNT(WAKE_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] st, input logic e, input logic a);
    chk({tag, ".state"}, 32'(STATE), 32'(st));
    chk({tag, ".E"},     32'(E),     32'(e));
    chk({tag, ".ACK"},   32'(ACK),   32'(a));
  endtask

  // One full OFF->WAKE->ON->DRAIN->OFF pass with IDLE_LIM=0.
  task automatic wake_pass(input string tag, input logic [15:0] exp_cnt);
    IDLE_LIM = 8'd0;
    REQ = 1'b1; tick(); chk_out({tag, ".w0"}, 2'b01, 1, 0);
    chk({tag, ".cnt"}, 32'(WAKE_CNT), 32'(exp_cnt));
    tick(); chk_out({tag, ".w1"}, 2'b01, 1, 0);
    tick(); chk_out({tag, ".on"}, 2'b10, 1, 1);
    REQ = 1'b0; tick(); chk_out({tag, ".dr"}, 2'b11, 1, 1);
    tick(); chk_out({tag, ".off"}, 2'b00, 0, 0);
  endtask

  initial begin
    RST = 1'b1; REQ = 1'b1; TE = 1'b0; IDLE_LIM = 8'd3;
    #2;
    // Reset holds OFF even with REQ high.
    tick(); tick();
    chk_out("rst", 2'b00, 0, 0);
    chk("rst.cnt", 32'(WAKE_CNT), 32'd0);
    TE = 1'b1; #1;
    chk_out("rst_te", 2'b00, 1, 1);
    TE = 1'b0; #1;

    // Wake: WAKE for two edges, ACK from the third.
    RST = 1'b0;
    tick(); chk_out("wk0", 2'b01, 1, 0);
    chk("wk0.cnt", 32'(WAKE_CNT), 32'd1);
    tick(); chk_out("wk1", 2'b01, 1, 0);
    tick(); chk_out("wk2", 2'b10, 1, 1);
    tick(); chk_out("on_hold", 2'b10, 1, 1);

    // Drain with IDLE_LIM=3; changing the limit mid-drain has no effect.
    REQ = 1'b0;
    tick(); chk_out("dr0", 2'b11, 1, 1);
    IDLE_LIM = 8'd0;
    tick(); chk_out("dr1", 2'b11, 1, 1);
    tick(); chk_out("dr2", 2'b11, 1, 1);
    tick(); chk_out("dr3", 2'b11, 1, 1);
    tick(); chk_out("dr_off", 2'b00, 0, 0);
    tick(); chk_out("off_idle", 2'b00, 0, 0);

    // Re-request on the second drain cycle returns to ON without a wake.
    IDLE_LIM = 8'd3; REQ = 1'b1;
    tick(); chk_out("rr_w0", 2'b01, 1, 0);
    tick(); tick(); chk_out("rr_on", 2'b10, 1, 1);
    REQ = 1'b0;
    tick(); chk_out("rr_d0", 2'b11, 1, 1);
    tick(); chk_out("rr_d1", 2'b11, 1, 1);
    REQ = 1'b1;
    tick(); chk_out("rr_back", 2'b10, 1, 1);
    chk("rr.cnt", 32'(WAKE_CNT), 32'd2);

    // IDLE_LIM=0 gives a single drain cycle.
    IDLE_LIM = 8'd0; REQ = 1'b0;
    tick(); chk_out("z_dr", 2'b11, 1, 1);
    tick(); chk_out("z_off", 2'b00, 0, 0);

    // One-cycle REQ pulse still runs a full wake.
    REQ = 1'b1;
    tick(); chk_out("p_w0", 2'b01, 1, 0);
    chk("p.cnt", 32'(WAKE_CNT), 32'd3);
    REQ = 1'b0;
    tick(); chk_out("p_w1", 2'b01, 1, 0);
    tick(); chk_out("p_on", 2'b10, 1, 1);
    tick(); chk_out("p_dr", 2'b11, 1, 1);
    tick(); chk_out("p_off", 2'b00, 0, 0);

    // TE in OFF forces E/ACK but the FSM stays put.
    TE = 1'b1; #1;
    chk_out("te_off", 2'b00, 1, 1);
    tick(); chk_out("te_off2", 2'b00, 1, 1);

    // TE does not disturb sequencing; then reset mid-WAKE.
    REQ = 1'b1;
    tick(); chk_out("te_wk", 2'b01, 1, 1);
    chk("te_wk.cnt", 32'(WAKE_CNT), 32'd4);
    TE = 1'b0; #1;
    chk_out("te_drop", 2'b01, 1, 0);
    RST = 1'b1;
    tick(); chk_out("rst_wk", 2'b00, 0, 0);
    chk("rst_wk.cnt", 32'(WAKE_CNT), 32'd0);

    // Reset mid-DRAIN.
    RST = 1'b0; IDLE_LIM = 8'd5;
    tick(); tick(); tick(); chk_out("m_on", 2'b10, 1, 1);
    REQ = 1'b0;
    tick(); tick(); chk_out("m_dr", 2'b11, 1, 1);
    RST = 1'b1;
    tick(); chk_out("rst_dr", 2'b00, 0, 0);
    chk("rst_dr.cnt", 32'(WAKE_CNT), 32'd0);
    RST = 1'b0;
    tick();

    // Saturation: preload near the top, then three wakes.
    force dut.wcnt_q = 16'hFFFE;
    #1;
    release dut.wcnt_q;
    #1;
    chk("sat.pre", 32'(WAKE_CNT), 32'h0000FFFE);
    wake_pass("sat1", 16'hFFFF);
    wake_pass("sat2", 16'hFFFF);
    wake_pass("sat3", 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
